// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, types and constants for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with flush > issue > writeback priority
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_reg,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_reg,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             any_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      // issue applied after writeback so the newer producer keeps the register
      if (wb_en && (wb_reg != AW'(REG_ZERO)))
        busy_d[wb_reg] = 1'b0;
      if (issue_en && (issue_reg != AW'(REG_ZERO)))
        busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy     = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NUM_RD-read / 1-write register file with x0 hardwired and busy scoreboard
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN   = XLEN_DEF,
  parameter int  NREGS  = NREGS_DEF,
  parameter int  NUM_RD = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*AW-1:0]     rdAddr,
  output logic [NUM_RD*XLEN-1:0]   rdData,
  output logic [NUM_RD-1:0]        rdBusy,
  input  logic                     regWen,
  input  logic [AW-1:0]            writeReg,
  input  logic [XLEN-1:0]          writeData,
  input  logic                     issueEn,
  input  logic [AW-1:0]            issueReg,
  input  logic                     flush,
  output logic                     anyBusy
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_hit;

  assign wr_hit = regWen && (writeReg != AW'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_hit)
      regs_d[writeReg] = writeData;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (Clk),
    .rst_n     (Rst),
    .issue_en  (issueEn),
    .issue_reg (issueReg),
    .wb_en     (regWen),
    .wb_reg    (writeReg),
    .flush     (flush),
    .busy      (busy),
    .any_busy  (anyBusy)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          addr_nz;

    assign addr    = rdAddr[gi*AW +: AW];
    assign addr_nz = (addr != AW'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    logic fwd;
    // wr_hit already excludes x0, so a forward never targets address 0
    assign fwd = wr_hit && (writeReg == addr);
    assign rdData[gi*XLEN +: XLEN] = fwd ? writeData : (addr_nz ? regs_q[addr] : '0);
    assign rdBusy[gi]              = addr_nz && !fwd && busy[addr];
`else
    assign rdData[gi*XLEN +: XLEN] = addr_nz ? regs_q[addr] : '0;
    assign rdBusy[gi]              = addr_nz && busy[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with randomized traffic and directed corner cases
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NR = 3;
  localparam int AW = AW_DEF;
  localparam int XL = XLEN_DEF;

  typedef struct packed {
    logic [NR*XL-1:0] data;
    logic [NR-1:0]    busy;
    logic             any;
  } exp_t;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NR*AW-1:0]  rdAddr;
  logic [NR*XL-1:0]  rdData;
  logic [NR-1:0]     rdBusy;
  logic              regWen;
  logic [AW-1:0]     writeReg;
  logic [XL-1:0]     writeData;
  logic              issueEn;
  logic [AW-1:0]     issueReg;
  logic              flush;
  logic              anyBusy;

  regfile_mp #(
    .XLEN   (XL),
    .NREGS  (NREGS_DEF),
    .NUM_RD (NR)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .rdBusy    (rdBusy),
    .regWen    (regWen),
    .writeReg  (writeReg),
    .writeData (writeData),
    .issueEn   (issueEn),
    .issueReg  (issueReg),
    .flush     (flush),
    .anyBusy   (anyBusy)
  );

  always #5 Clk = ~Clk;

  reg_data_t m_reg  [NREGS_DEF];
  bit        m_busy [NREGS_DEF];
  exp_t      exp_q  [$];
  int        checks = 0;
  int        errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic model_reset();
    for (int r = 0; r < NREGS_DEF; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.any = 1'b0;
    for (int r = 0; r < NREGS_DEF; r++) e.any |= m_busy[r];
    for (int p = 0; p < NR; p++) begin
      reg_addr_t a;
      a = rdAddr[p*AW +: AW];
      if (a == 0) begin
        e.data[p*XL +: XL] = '0;
        e.busy[p]          = 1'b0;
      end else if (BYPASS && Rst && regWen && writeReg == a) begin
        e.data[p*XL +: XL] = writeData;
        e.busy[p]          = 1'b0;
      end else begin
        e.data[p*XL +: XL] = m_reg[a];
        e.busy[p]          = m_busy[a];
      end
    end
    return e;
  endfunction

  task automatic model_clock();
    if (regWen && writeReg != 0) m_reg[writeReg] = writeData;
    if (flush) begin
      for (int r = 0; r < NREGS_DEF; r++) m_busy[r] = 1'b0;
    end else begin
      if (regWen && writeReg != 0) m_busy[writeReg] = 1'b0;
      if (issueEn && issueReg != 0) m_busy[issueReg] = 1'b1;
    end
  endtask

  function automatic logic [NR*AW-1:0] all_addr(input int a);
    logic [NR*AW-1:0] v;
    for (int p = 0; p < NR; p++) v[p*AW +: AW] = AW'(a);
    return v;
  endfunction

  task automatic step(input logic [NR*AW-1:0] ra, input logic we, input int wr,
                      input logic [XL-1:0] wd, input logic ie, input int ir, input logic fl);
    rdAddr    = ra;
    regWen    = we;
    writeReg  = AW'(wr);
    writeData = wd;
    issueEn   = ie;
    issueReg  = AW'(ir);
    flush     = fl;
    exp_q.push_back(predict());
    @(posedge Clk);
    model_clock();
    #1;
  endtask

  task automatic idle_read(input int a);
    step(all_addr(a), 1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rdData !== e.data) begin
        errors++;
        $display("FAIL rd_data t=%0t addr=%h got %h want %h", $time, rdAddr, rdData, e.data);
      end
      checks++;
      if (rdBusy !== e.busy) begin
        errors++;
        $display("FAIL rd_busy t=%0t addr=%h got %b want %b", $time, rdAddr, rdBusy, e.busy);
      end
      checks++;
      if (anyBusy !== e.any) begin
        errors++;
        $display("FAIL any_busy t=%0t got %b want %b", $time, anyBusy, e.any);
      end
    end
  end

  initial begin
    logic [NR*AW-1:0] ra;
    Rst = 1'b0;
    rdAddr = '0; regWen = 1'b0; writeReg = '0; writeData = '0;
    issueEn = 1'b0; issueReg = '0; flush = 1'b0;
    model_reset();

    // reset held: outputs must already be zero
    rdAddr = {AW'(31), AW'(17), AW'(1)};
    exp_q.push_back(predict());
    @(negedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;

    for (int a = 0; a < NREGS_DEF; a += NR) begin
      for (int p = 0; p < NR; p++) ra[p*AW +: AW] = AW'((a + p) % NREGS_DEF);
      step(ra, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    end

    step(all_addr(0), 1'b1, 0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    step(all_addr(0), 1'b0, 0, '0, 1'b1, 0, 1'b0);
    idle_read(0);

    step(all_addr(5), 1'b1, 5, 32'h12345678, 1'b0, 0, 1'b0);
    idle_read(5);

    step(all_addr(7), 1'b0, 0, '0, 1'b1, 7, 1'b0);
    idle_read(7);
    idle_read(7);
    step(all_addr(7), 1'b1, 7, 32'h000000A5, 1'b0, 0, 1'b0);
    idle_read(7);

    step(all_addr(9), 1'b1, 9, 32'h99, 1'b1, 9, 1'b0);
    idle_read(9);
    step(all_addr(9), 1'b0, 0, '0, 1'b1, 9, 1'b1);
    idle_read(9);

    step(all_addr(3), 1'b1, 3, 32'h55, 1'b0, 0, 1'b0);
    step(all_addr(4), 1'b1, 4, 32'h55, 1'b1, 4, 1'b0);
    idle_read(4);
    // async reset between edges, checked before any further posedge
    rdAddr = {AW'(4), AW'(3), AW'(4)};
    regWen = 1'b0; issueEn = 1'b0; flush = 1'b0;
    Rst = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(predict());
    @(negedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    idle_read(4);

    for (int n = 0; n < 400; n++) begin
      logic we, ie, fl;
      int   wr, ir;
      we = ($urandom_range(0, 1) == 1);
      ie = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 19) == 0);
      wr = $urandom_range(0, NREGS_DEF - 1);
      ir = $urandom_range(0, 3) == 0 ? wr : $urandom_range(0, NREGS_DEF - 1);
      for (int p = 0; p < NR; p++)
        ra[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? AW'(wr) : AW'($urandom_range(0, NREGS_DEF - 1));
      step(ra, we, wr, $urandom, ie, ir, fl);
    end

    repeat (2) @(posedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
